// File: rtl/bridge_pkg.sv
// Shared types and constants for the ASCII bridge receiver.
package bridge_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_END, DATA, DATA_END, ERROR} state_t;

  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;
  localparam logic [7:0] PREAMBLE_DEF = 8'h4D;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BADCHAR = 2'd1;
  localparam logic [1:0] ERR_TERM    = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF);
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// ASCII hex digit decoder, accepts upper- and lowercase.
module hex_nibble_decode (
  input  logic [7:0] i_data,
  output logic       o_is_hex,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_is_hex = 1'b1;
    o_nibble = 4'd0;
    if (i_data >= 8'h30 && i_data <= 8'h39)
      o_nibble = i_data[3:0];
    else if ((i_data >= 8'h41 && i_data <= 8'h46) || (i_data >= 8'h61 && i_data <= 8'h66))
      o_nibble = i_data[3:0] + 4'd9;
    else
      o_is_hex = 1'b0;
  end

endmodule

// File: rtl/bridge_rx_param.sv
// ASCII "M<addr><data><CR|LF>" command parser with ready/valid request output.
// Optional saturating error counter output when BRIDGE_RX_PARAM_ERRCNT_EN is defined.
module bridge_rx_param
  import bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16,
  parameter logic [7:0]  PREAMBLE   = PREAMBLE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o,
`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
  output logic [15:0]           err_count_o,
`endif
  output logic [1:0]            err_code_o
);

  localparam int AD      = (ADDR_WIDTH + 3) / 4;
  localparam int DD      = (DATA_WIDTH + 3) / 4;
  localparam int CNT_MAX = (AD > DD) ? AD : DD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic       w_is_hex;
  logic [3:0] w_nib;

  hex_nibble_decode u_dec (
    .i_data   (rx_data),
    .o_is_hex (w_is_hex),
    .o_nibble (w_nib)
  );

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_sh, r_addr;
  logic [DATA_WIDTH-1:0] r_data_sh, r_wdata;
  logic                  r_rw, r_valid, r_err;
  logic [1:0]            r_code;

  logic w_term, w_hex_ok;
  logic w_clr, w_sh_addr, w_sh_data, w_done_rd, w_done_wr, w_err_bad, w_err_term;

  assign w_term   = is_term(rx_data);
  // The preamble is never a digit, even if a custom preamble happens to be hex.
  assign w_hex_ok = w_is_hex && (rx_data != PREAMBLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_sh_addr   = 1'b0;
    w_sh_data   = 1'b0;
    w_done_rd   = 1'b0;
    w_done_wr   = 1'b0;
    w_err_bad   = 1'b0;
    w_err_term  = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE: if (rx_data == PREAMBLE) begin
          w_state_nxt = ADDR;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
        ADDR: if (w_hex_ok) begin
          w_sh_addr = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CW'(AD - 1)) w_state_nxt = ADDR_END;
        end else begin
          w_state_nxt = ERROR;
          w_err_bad   = 1'b1;
        end
        ADDR_END: if (w_term) begin
          w_state_nxt = IDLE;
          w_done_rd   = 1'b1;
        end else if (w_hex_ok) begin
          w_sh_data   = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = (DD == 1) ? DATA_END : DATA;
        end else begin
          w_state_nxt = ERROR;
          w_err_bad   = 1'b1;
        end
        DATA: if (w_hex_ok) begin
          w_sh_data = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CW'(DD - 1)) w_state_nxt = DATA_END;
        end else begin
          w_state_nxt = ERROR;
          w_err_bad   = 1'b1;
        end
        DATA_END: if (w_term) begin
          w_state_nxt = IDLE;
          w_done_wr   = 1'b1;
        end else begin
          w_state_nxt = ERROR;
          w_err_term  = 1'b1;
        end
        ERROR: if (w_term) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  logic w_done, w_free, w_load, w_ovf, w_err;
  assign w_done = w_done_rd | w_done_wr;
  assign w_free = !r_valid || ready_i;
  assign w_load = w_done && w_free;
  assign w_ovf  = w_done && !w_free;
  assign w_err  = w_err_bad | w_err_term | w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_clr) begin
        r_addr_sh <= '0;
        r_data_sh <= '0;
      end else begin
        // Truncating shift drops the excess MSBs of the leading digit.
        if (w_sh_addr) r_addr_sh <= ADDR_WIDTH'({r_addr_sh, w_nib});
        if (w_sh_data) r_data_sh <= DATA_WIDTH'({r_data_sh, w_nib});
      end
      if (w_load) begin
        r_addr  <= r_addr_sh;
        r_wdata <= w_done_wr ? r_data_sh : '0;
        r_rw    <= w_done_wr;
        r_valid <= 1'b1;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
      r_err <= w_err;
      if (w_err) r_code <= w_err_bad ? ERR_BADCHAR : (w_err_term ? ERR_TERM : ERR_OVF);
    end
  end

  assign addr_o     = r_addr;
  assign wdata_o    = r_wdata;
  assign rw_o       = r_rw;
  assign valid_o    = r_valid;
  assign err_o      = r_err;
  assign err_code_o = r_code;

`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_err_cnt <= '0;
    else if (r_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign err_count_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_bridge_rx_param.sv
// Bench for bridge_rx_param: directed scenarios plus randomized command stream vs a line-level model.
module tb_bridge_rx_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, rx_valid2 = 1'b0;
  logic        ready = 1'b1, ready2 = 1'b1;
  logic [15:0] addr_o, wdata_o;
  logic        rw_o, valid_o, err_o;
  logic [1:0]  err_code_o;
  logic [9:0]  addr2;
  logic [11:0] wdata2;
  logic        rw2, valid2, err2;
  logic [1:0]  code2;
`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
  logic [15:0] err_count_o, err_count2;
`endif

  always #5 clk = ~clk;

  bridge_rx_param dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .ready_i(ready), .err_o(err_o),
`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
    .err_count_o(err_count_o),
`endif
    .err_code_o(err_code_o)
  );

  bridge_rx_param #(.ADDR_WIDTH(10), .DATA_WIDTH(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid2),
    .addr_o(addr2), .wdata_o(wdata2), .rw_o(rw2), .valid_o(valid2),
    .ready_i(ready2), .err_o(err2),
`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
    .err_count_o(err_count2),
`endif
    .err_code_o(code2)
  );

  typedef struct { logic [15:0] addr; logic [15:0] data; logic rw; } txn_t;

  int   n_pass = 0, n_tot = 0;
  int   hs_cnt = 0, mon_err = 0, err_base = 0;
  txn_t hs_q[$];

  always @(negedge clk) begin
    if (valid_o && ready) begin
      hs_q.push_back('{addr: addr_o, data: wdata_o, rw: rw_o});
      hs_cnt++;
    end
    if (err_o) mon_err++;
  end

  task automatic send_byte(input logic [7:0] b, input bit to2);
    rx_data = b;
    if (to2) rx_valid2 = 1'b1; else rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_valid2 = 1'b0;
  endtask

  task automatic send_str(input string s, input bit to2);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], to2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    n_tot++; if (valid_o !== 1'b0)      $display("FAIL reset_valid got %0b want 0", valid_o); else n_pass++;
    n_tot++; if (addr_o !== 16'h0)      $display("FAIL reset_addr got %h want 0000", addr_o); else n_pass++;
    n_tot++; if (wdata_o !== 16'h0)     $display("FAIL reset_wdata got %h want 0000", wdata_o); else n_pass++;
    n_tot++; if (rw_o !== 1'b0 || err_o !== 1'b0) $display("FAIL reset_rw_err got %0b%0b want 00", rw_o, err_o); else n_pass++;
    n_tot++; if (err_code_o !== 2'd0)   $display("FAIL reset_code got %0d want 0", err_code_o); else n_pass++;
  endtask

  task automatic test_read;
    int h0;
    h0 = hs_cnt;
    send_str("M1234", 1'b0);
    n_tot++; if (valid_o !== 1'b0) $display("FAIL read_early_valid got %0b want 0", valid_o); else n_pass++;
    send_byte(8'h0D, 1'b0);
    n_tot++; if (valid_o !== 1'b1) $display("FAIL read_valid got %0b want 1", valid_o); else n_pass++;
    n_tot++; if (addr_o !== 16'h1234 || rw_o !== 1'b0 || wdata_o !== 16'h0)
      $display("FAIL read_fields got addr=%h rw=%0b wdata=%h want 1234/0/0000", addr_o, rw_o, wdata_o); else n_pass++;
    idle(1);
    n_tot++; if (valid_o !== 1'b0) $display("FAIL read_drop got %0b want 0", valid_o); else n_pass++;
    n_tot++; if (hs_cnt - h0 !== 1) $display("FAIL read_hs got %0d want 1", hs_cnt - h0); else n_pass++;
  endtask

  task automatic test_lowercase_write;
    send_str("M3ffabc", 1'b1);
    send_byte(8'h0A, 1'b1);
    n_tot++; if (valid2 !== 1'b1 || addr2 !== 10'h3FF || wdata2 !== 12'hABC || rw2 !== 1'b1)
      $display("FAIL lower_write got v=%0b addr=%h wdata=%h rw=%0b want 1/3ff/abc/1", valid2, addr2, wdata2, rw2);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_backpressure;
    int h0, e0;
    ready = 1'b0;
    h0 = hs_cnt; e0 = mon_err;
    send_str("M0001", 1'b0); send_byte(8'h0D, 1'b0);
    n_tot++; if (valid_o !== 1'b1 || addr_o !== 16'h0001) $display("FAIL bp_first got v=%0b addr=%h want 1/0001", valid_o, addr_o); else n_pass++;
    send_str("M0002", 1'b0); send_byte(8'h0D, 1'b0);
    n_tot++; if (err_o !== 1'b1 || err_code_o !== 2'd3) $display("FAIL bp_ovf got err=%0b code=%0d want 1/3", err_o, err_code_o); else n_pass++;
    n_tot++; if (valid_o !== 1'b1 || addr_o !== 16'h0001) $display("FAIL bp_hold got v=%0b addr=%h want 1/0001", valid_o, addr_o); else n_pass++;
    idle(2);
    ready = 1'b1;
    idle(1);
    n_tot++; if (valid_o !== 1'b0) $display("FAIL bp_release got %0b want 0", valid_o); else n_pass++;
    idle(1);
    n_tot++; if (hs_cnt - h0 !== 1 || mon_err - e0 !== 1)
      $display("FAIL bp_counts got hs=%0d err=%0d want 1/1", hs_cnt - h0, mon_err - e0); else n_pass++;
  endtask

  task automatic test_badchar;
    int h0;
    h0 = hs_cnt;
    send_str("M12G", 1'b0);
    n_tot++; if (err_o !== 1'b1 || err_code_o !== 2'd1) $display("FAIL bad_code got err=%0b code=%0d want 1/1", err_o, err_code_o); else n_pass++;
    send_str("4", 1'b0); send_byte(8'h0D, 1'b0);
    idle(1);
    n_tot++; if (valid_o !== 1'b0 || hs_cnt !== h0) $display("FAIL bad_noissue got v=%0b hs=%0d want 0/%0d", valid_o, hs_cnt, h0); else n_pass++;
    send_str("M00AA", 1'b0); send_byte(8'h0D, 1'b0);
    n_tot++; if (valid_o !== 1'b1 || addr_o !== 16'h00AA) $display("FAIL bad_recover got v=%0b addr=%h want 1/00aa", valid_o, addr_o); else n_pass++;
    idle(1);
  endtask

  task automatic test_missing_term;
    send_str("M0001BEEFX", 1'b0);
    n_tot++; if (err_o !== 1'b1 || err_code_o !== 2'd2) $display("FAIL term_code got err=%0b code=%0d want 1/2", err_o, err_code_o); else n_pass++;
    send_byte(8'h0D, 1'b0);
    send_str("M0002", 1'b0); send_byte(8'h0D, 1'b0);
    n_tot++; if (valid_o !== 1'b1 || addr_o !== 16'h0002 || rw_o !== 1'b0)
      $display("FAIL term_recover got v=%0b addr=%h rw=%0b want 1/0002/0", valid_o, addr_o, rw_o); else n_pass++;
    idle(1);
  endtask

  task automatic test_async_reset;
    send_str("M12", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if (valid_o !== 1'b0 || addr_o !== 16'h0 || wdata_o !== 16'h0 || rw_o !== 1'b0 || err_o !== 1'b0 || err_code_o !== 2'd0)
      $display("FAIL arst_outputs got v=%0b addr=%h wd=%h rw=%0b err=%0b code=%0d want all 0",
               valid_o, addr_o, wdata_o, rw_o, err_o, err_code_o); else n_pass++;
`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
    n_tot++; if (err_count_o !== 16'h0) $display("FAIL arst_errcnt got %0d want 0", err_count_o); else n_pass++;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_base = mon_err;
    send_str("0005", 1'b0); send_byte(8'h0D, 1'b0);
    n_tot++; if (valid_o !== 1'b0) $display("FAIL arst_discard got v=%0b want 0", valid_o); else n_pass++;
    send_str("M0005", 1'b0); send_byte(8'h0D, 1'b0);
    n_tot++; if (valid_o !== 1'b1 || addr_o !== 16'h0005) $display("FAIL arst_after got v=%0b addr=%h want 1/0005", valid_o, addr_o); else n_pass++;
    idle(1);
  endtask

  // Line-level reference: tracks only "collecting", "discarding" and the digit count.
  localparam int AD = 4, DD = 4;
  int         m_mode, m_len, m_errs;
  logic [1:0] m_code;
  logic [15:0] m_addr, m_data;
  txn_t       exp_q[$];

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] rand_hex;
    int v;
    v = $urandom_range(0, 15);
    if (v < 10) return 8'(48 + v);
    return 8'(($urandom_range(0, 1) ? 87 : 55) + v);
  endfunction

  task automatic model_err(input logic [1:0] c);
    m_errs++; m_code = c; m_mode = 2;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit term;
    int hv;
    term = (b == 8'h0D) || (b == 8'h0A);
    hv = hexval(b);
    if (m_mode == 0) begin
      if (b == 8'h4D) begin m_mode = 1; m_len = 0; m_addr = 0; m_data = 0; end
    end else if (m_mode == 1) begin
      if (term) begin
        if (m_len == AD)           begin exp_q.push_back('{addr: m_addr, data: 16'h0, rw: 1'b0}); m_mode = 0; end
        else if (m_len == AD + DD) begin exp_q.push_back('{addr: m_addr, data: m_data, rw: 1'b1}); m_mode = 0; end
        else model_err(2'd1);
      end else if (m_len == AD + DD) model_err(2'd2);
      else if (hv < 0) model_err(2'd1);
      else begin
        if (m_len < AD) m_addr = 16'((m_addr * 16) + hv);
        else            m_data = 16'((m_data * 16) + hv);
        m_len++;
      end
    end else if (term) m_mode = 0;
  endtask

  task automatic test_random;
    logic [7:0] cmd[$];
    logic [7:0] bad[4];
    int kind, e0;
    bad[0] = "G"; bad[1] = "z"; bad[2] = "M"; bad[3] = " ";
    ready = 1'b1;
    hs_q.delete(); exp_q.delete();
    m_mode = 0; m_len = 0; m_errs = 0; m_code = 2'd0;
    e0 = mon_err;
    for (int n = 0; n < 40; n++) begin
      cmd.delete();
      kind = $urandom_range(0, 4);
      if (kind == 4) begin
        repeat ($urandom_range(1, 4)) cmd.push_back(8'($urandom_range(8'h20, 8'h4C)));
      end else begin
        cmd.push_back(8'h4D);
        repeat (AD) cmd.push_back(rand_hex());
        if (kind != 0) repeat (DD) cmd.push_back(rand_hex());
        if (kind == 2) cmd[$urandom_range(1, cmd.size() - 1)] = bad[$urandom_range(0, 3)];
        if (kind == 3) cmd.push_back(rand_hex());
      end
      cmd.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 3) == 0) cmd.push_back(8'h0A);
      foreach (cmd[i]) begin
        model_byte(cmd[i]);
        send_byte(cmd[i], 1'b0);
        idle($urandom_range(0, 2));
      end
    end
    idle(3);
    n_tot++; if (hs_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d want %0d", hs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      n_tot++;
      if (hs_q[i].addr !== exp_q[i].addr || hs_q[i].data !== exp_q[i].data || hs_q[i].rw !== exp_q[i].rw)
        $display("FAIL rand_txn%0d got %h/%h/%0b want %h/%h/%0b", i, hs_q[i].addr, hs_q[i].data, hs_q[i].rw,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].rw);
      else n_pass++;
    end
    n_tot++; if (mon_err - e0 !== m_errs) $display("FAIL rand_errs got %0d want %0d", mon_err - e0, m_errs); else n_pass++;
    n_tot++; if (err_code_o !== m_code) $display("FAIL rand_code got %0d want %0d", err_code_o, m_code); else n_pass++;
`ifdef BRIDGE_RX_PARAM_ERRCNT_EN
    n_tot++; if (err_count_o !== 16'(mon_err - err_base)) $display("FAIL rand_errcnt got %0d want %0d", err_count_o, mon_err - err_base); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_lowercase_write();
    test_backpressure();
    test_badchar();
    test_missing_term();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/bridge_rx_param.md
Name: bridge_rx_param

Overview:
- Parametrised successor to the ASCII bridge receiver. Parses UART byte stream commands "M<addr hex><CR|LF>" (read) and "M<addr hex><data hex><CR|LF>" (write) into bus requests.
- Adds over the previous generation:
  - arbitrary address/data widths;
  - a real ready/valid output handshake;
  - lowercase hex;
  - error reporting and self-recovery from ERROR.
- Sits between uart_rx and the core-chain bus master.

Parameters:
- ADDR_WIDTH, 16, address bits; address digit count AD = (ADDR_WIDTH+3)/4
- DATA_WIDTH, 16, write-data bits; data digit count DD = (DATA_WIDTH+3)/4
- PREAMBLE, 8'h4D, command start character ('M')

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid, single-cycle strobe per byte
- addr_o  out  ADDR_WIDTH  request address
- wdata_o  out  DATA_WIDTH  write data (0 for reads)
- rw_o  out  1  1 = write, 0 = read
- valid_o  out  1  request valid
- ready_i  in  1  downstream accepts request when valid_o & ready_i
- err_o  out  1  one-cycle pulse on any error
- err_code_o  out  2  last error: 0 none, 1 bad character, 2 bad/missing terminator, 3 overflow; held until next error

Behaviour:
Reset:
- rst_n low clears all outputs to 0, digit counter and shift registers to 0, state to IDLE.
- Async assert; deassert is synchronised externally.
- Reset mid-command discards the partial command.

Hex decode:
- '0'-'9', 'A'-'F' and 'a'-'f' are valid; anything else is invalid.
- Accumulate: reg <= {reg, nibble} truncated to width. When width is not a multiple of 4, the excess MSBs of the first digit are discarded.

FSM (advances only on rx_valid):
- IDLE: PREAMBLE -> ADDR, clear shift registers and counter. All other bytes (including CR/LF) are ignored silently.
- ADDR: hex -> shift into addr, count++. After AD digits -> ADDR_END. Non-hex -> ERROR, code 1.
- ADDR_END:
  - CR/LF -> read complete.
  - hex -> shift first data digit, count = 1, go to DATA (if DD = 1, go to DATA_END).
  - Other -> ERROR, code 1.
- DATA: hex -> shift into data, count++. After DD digits -> DATA_END. Non-hex -> ERROR, code 1.
- DATA_END: CR/LF -> write complete. Anything else -> ERROR, code 2.
- ERROR: discard bytes until CR or LF, then IDLE. PREAMBLE seen in ERROR is also discarded.
- A PREAMBLE byte mid-command is a bad character (code 1).

Completion and handshake:
- The slot is free if valid_o == 0, or valid_o & ready_i in the same cycle.
- Free slot: addr_o, wdata_o and rw_o load on the terminator cycle; valid_o = 1 on the next cycle (1-cycle latency from the terminator strobe).
- Occupied slot (valid_o & !ready_i): the new command is dropped, err_o pulses, code 3, outputs are unchanged.
- Outputs hold stable while valid_o & !ready_i. valid_o drops the cycle after the handshake unless a new command loads simultaneously; back-to-back issue is allowed.
- The parser keeps accepting bytes while a request is pending (one-command lookahead, no stall of rx).
- State returns to IDLE on completion. A trailing LF after CR is ignored in IDLE.
- err_o and a completion never coincide in the same cycle.

Optional Feature:
- Macro: BRIDGE_RX_PARAM_ERRCNT_EN.
- When defined: extra output err_count_o [15:0], a saturating count of err_o pulses (stays at 16'hFFFF). Cleared only by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bridge_pkg holds:
  - state enum (IDLE, ADDR, ADDR_END, DATA, DATA_END, ERROR);
  - char constants (CR 8'h0D, LF 8'h0A, default preamble);
  - error-code localparams.
- One sub-module, hex_nibble_decode: combinational, rx_data -> {is_hex, nibble[3:0]}.

Test Plan:
- Read: "M1234\r", ready_i = 1 -> one cycle after '\r': valid_o = 1, addr_o = 16'h1234, rw_o = 0, wdata_o = 0; valid_o = 0 next cycle.
- Write, lowercase, ADDR_WIDTH = 10, DATA_WIDTH = 12: "M3ffabc\n" -> addr_o = 10'h3FF, wdata_o = 12'hABC, rw_o = 1.
- Backpressure: ready_i = 0, send "M0001\r" then "M0002\r" -> first request held at addr 0001; second dropped with err_o pulse and err_code_o = 3. Raise ready_i -> single handshake, valid_o = 0.
- Bad character and recovery: "M12G4\r" -> err_code_o = 1, no valid_o. Then "M00AA\r" -> addr_o = 16'h00AA accepted.
- Missing terminator: "M0001BEEFX\rM0002\r" -> err_code_o = 2, then read of 0002 issued.
- Async reset asserted mid-"M12" -> all outputs 0; subsequent "M0005\r" -> addr_o = 16'h0005. With BRIDGE_RX_PARAM_ERRCNT_EN, err_count_o reads 0 after reset and increments per error.
